mem_wb_stage: RTL and testbench

Memory-access and write-back stage that consumes the execute-stage result bundle (ALU result, destination register, memory/store/write-enable controls) and completes each instruction. It issues a req/ack handshake to the data memory for loads and stores, stalls the upstream pipeline while a memory access is outstanding, and drives the single register-file write port. It sits between the execute stage and the register file / data-memory port of the 16-bit-instruction, 8-register, 32-bit-datapath core.

---
 rtl/mem_wb_stage_pkg.sv | 18 +
 rtl/mem_wb_stage_if.sv | 44 ++++
 rtl/mem_wb_stage.sv | 121 ++++++++++++
 tb/tb_mem_wb_stage.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_wb_stage_pkg.sv
// Shared definitions for the memory-access / write-back stage: widths, FSM states and
// the alignment helper used by the stage.
package mem_wb_stage_pkg;

  localparam int unsigned RegAddrW = 3;
  localparam int unsigned DataW    = 32;

  typedef enum logic [1:0] {
    StIdle,
    StMem,
    StWb
  } state_e;

  function automatic logic is_word_aligned(input logic [1:0] lsbs);
    return lsbs == 2'b00;
  endfunction

endpackage

// File: rtl/mem_wb_stage_if.sv
// Bundle, data-memory and register-file signals of the mem/wb stage. The stage
// itself uses the slave view; the execute stage / memory / environment uses master.
interface mem_wb_stage_if
  import mem_wb_stage_pkg::*;
#(
  parameter int unsigned ADDR_W = 16
) ();

  logic                ex_valid;
  logic [DataW-1:0]    ex_data;
  logic [DataW-1:0]    ex_store_data;
  logic                ex_mem_inst;
  logic                ex_store;
  logic                ex_WR;
  logic [RegAddrW-1:0] ex_addr_dest;
  logic                stall;

  logic                dmem_req;
  logic                dmem_we;
  logic [ADDR_W-1:0]   dmem_addr;
  logic [DataW-1:0]    dmem_wdata;
  logic [DataW-1:0]    dmem_rdata;
  logic                dmem_ack;

  logic                rf_wen;
  logic [RegAddrW-1:0] rf_waddr;
  logic [DataW-1:0]    rf_wdata;
  logic                misalign;

  modport master (
    output ex_valid, ex_data, ex_store_data, ex_mem_inst, ex_store, ex_WR, ex_addr_dest,
    output dmem_rdata, dmem_ack,
    input  stall, dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  rf_wen, rf_waddr, rf_wdata, misalign
  );

  modport slave (
    input  ex_valid, ex_data, ex_store_data, ex_mem_inst, ex_store, ex_WR, ex_addr_dest,
    input  dmem_rdata, dmem_ack,
    output stall, dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output rf_wen, rf_waddr, rf_wdata, misalign
  );

endinterface

// File: rtl/mem_wb_stage.sv
// Memory-access and write-back stage: completes ALU results directly, runs loads/stores
// through a req/ack data-memory handshake and drives the single register-file write port.
module mem_wb_stage
  import mem_wb_stage_pkg::*;
#(
  parameter int unsigned ADDR_W = 16
) (
  input  logic         clk,
  input  logic         resetn,
  mem_wb_stage_if.slave bus
);

  state_e              r_state_q, w_state_d;
  logic [ADDR_W-1:0]   r_addr_q, w_addr_d;
  logic [DataW-1:0]    r_sdata_q, w_sdata_d;
  logic                r_store_q, w_store_d;
  logic                r_wr_q, w_wr_d;
  logic [RegAddrW-1:0] r_dest_q, w_dest_d;
  logic                r_rf_wen_q, w_rf_wen_d;
  logic [RegAddrW-1:0] r_rf_waddr_q, w_rf_waddr_d;
  logic [DataW-1:0]    r_rf_wdata_q, w_rf_wdata_d;
  logic                r_misalign_q, w_misalign_d;

  logic w_stall;
  logic w_accept;
  logic w_in_mem;

  assign w_stall  = (r_state_q != StIdle);
  assign w_accept = bus.ex_valid && !w_stall;
  assign w_in_mem = (r_state_q == StMem);

  always_comb begin
    w_state_d    = r_state_q;
    w_addr_d     = r_addr_q;
    w_sdata_d    = r_sdata_q;
    w_store_d    = r_store_q;
    w_wr_d       = r_wr_q;
    w_dest_d     = r_dest_q;
    w_rf_wen_d   = 1'b0;
    w_rf_waddr_d = r_rf_waddr_q;
    w_rf_wdata_d = r_rf_wdata_q;
    w_misalign_d = 1'b0;

    unique case (r_state_q)
      StIdle: begin
        if (w_accept) begin
          if (!bus.ex_mem_inst) begin
            w_rf_wen_d   = bus.ex_WR;
            w_rf_waddr_d = bus.ex_addr_dest;
            w_rf_wdata_d = bus.ex_data;
          end else if (!is_word_aligned(bus.ex_data[1:0])) begin
            w_misalign_d = 1'b1;
          end else begin
            w_addr_d  = bus.ex_data[ADDR_W-1:0];
            w_sdata_d = bus.ex_store_data;
            w_store_d = bus.ex_store;
            w_wr_d    = bus.ex_WR;
            w_dest_d  = bus.ex_addr_dest;
            w_state_d = StMem;
          end
        end
      end
      StMem: begin
        if (bus.dmem_ack) begin
          if (r_store_q) begin
            w_state_d = StIdle;
          end else begin
            // Load data goes straight into the shared rf output register.
            w_rf_wen_d   = r_wr_q;
            w_rf_waddr_d = r_dest_q;
            w_rf_wdata_d = bus.dmem_rdata;
            w_state_d    = StWb;
          end
        end
      end
      StWb: begin
        w_state_d = StIdle;
      end
      default: begin
        w_state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state_q    <= StIdle;
      r_addr_q     <= '0;
      r_sdata_q    <= '0;
      r_store_q    <= 1'b0;
      r_wr_q       <= 1'b0;
      r_dest_q     <= '0;
      r_rf_wen_q   <= 1'b0;
      r_rf_waddr_q <= '0;
      r_rf_wdata_q <= '0;
      r_misalign_q <= 1'b0;
    end else begin
      r_state_q    <= w_state_d;
      r_addr_q     <= w_addr_d;
      r_sdata_q    <= w_sdata_d;
      r_store_q    <= w_store_d;
      r_wr_q       <= w_wr_d;
      r_dest_q     <= w_dest_d;
      r_rf_wen_q   <= w_rf_wen_d;
      r_rf_waddr_q <= w_rf_waddr_d;
      r_rf_wdata_q <= w_rf_wdata_d;
      r_misalign_q <= w_misalign_d;
    end
  end

  assign bus.stall      = w_stall;
  assign bus.dmem_req   = w_in_mem;
  assign bus.dmem_we    = w_in_mem && r_store_q;
  assign bus.dmem_addr  = r_addr_q;
  assign bus.dmem_wdata = r_sdata_q;
  assign bus.rf_wen     = r_rf_wen_q;
  assign bus.rf_waddr   = r_rf_waddr_q;
  assign bus.rf_wdata   = r_rf_wdata_q;
  assign bus.misalign   = r_misalign_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: vector table, directed multi-cycle sequences and
// a randomized instruction stream against an instruction-level register/memory model.
module tb_mem_wb_stage;

  localparam int unsigned ADDR_W = 16;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  mem_wb_stage_if #(.ADDR_W(ADDR_W)) bus_if ();

  mem_wb_stage #(.ADDR_W(ADDR_W)) u_dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus_if)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic        mem;
    logic        st;
    logic        wr;
    logic [2:0]  dest;
    logic [31:0] data;
    logic        e_wen;
    logic        e_mis;
  } vec_t;

  logic [31:0] mem_model [16];
  logic [31:0] model_rf  [8];
  logic [31:0] obs_rf    [8];
  logic        rand_phase = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Control word: {stall, dmem_req, dmem_we, rf_wen, misalign}
  task automatic chk_ctl(input string tag, input logic [4:0] e);
    chk({tag, ".ctl"}, 32'({bus_if.stall, bus_if.dmem_req, bus_if.dmem_we, bus_if.rf_wen,
                            bus_if.misalign}), 32'(e));
  endtask

  task automatic chk_rf(input string tag, input logic [2:0] a, input logic [31:0] d);
    chk({tag, ".waddr"}, 32'(bus_if.rf_waddr), 32'(a));
    chk({tag, ".wdata"}, bus_if.rf_wdata, d);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic mem, input logic st, input logic wr,
                       input logic [2:0] dest, input logic [31:0] data,
                       input logic [31:0] sdata);
    bus_if.ex_valid      = v;
    bus_if.ex_mem_inst   = mem;
    bus_if.ex_store      = st;
    bus_if.ex_WR         = wr;
    bus_if.ex_addr_dest  = dest;
    bus_if.ex_data       = data;
    bus_if.ex_store_data = sdata;
  endtask

  task automatic drive_junk();
    drive(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 3'($urandom), $urandom,
          $urandom);
  endtask

  always @(negedge clk) begin
    if (rand_phase && bus_if.rf_wen) obs_rf[bus_if.rf_waddr] <= bus_if.rf_wdata;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt [8];
    vt[0] = '{mem: 1'b0, st: 1'b0, wr: 1'b1, dest: 3'd3, data: 32'h12345678, e_wen: 1'b1,
              e_mis: 1'b0};
    vt[1] = '{mem: 1'b0, st: 1'b0, wr: 1'b0, dest: 3'd1, data: 32'hDEADBEEF, e_wen: 1'b0,
              e_mis: 1'b0};
    vt[2] = '{mem: 1'b0, st: 1'b0, wr: 1'b1, dest: 3'd7, data: 32'h00000001, e_wen: 1'b1,
              e_mis: 1'b0};
    vt[3] = '{mem: 1'b1, st: 1'b0, wr: 1'b1, dest: 3'd2, data: 32'h00000042, e_wen: 1'b0,
              e_mis: 1'b1};
    vt[4] = '{mem: 1'b1, st: 1'b1, wr: 1'b1, dest: 3'd4, data: 32'h00000103, e_wen: 1'b0,
              e_mis: 1'b1};
    vt[5] = '{mem: 1'b0, st: 1'b1, wr: 1'b1, dest: 3'd0, data: 32'hFFFFFFFF, e_wen: 1'b1,
              e_mis: 1'b0};
    vt[6] = '{mem: 1'b1, st: 1'b0, wr: 1'b0, dest: 3'd6, data: 32'h00000001, e_wen: 1'b0,
              e_mis: 1'b1};
    vt[7] = '{mem: 1'b0, st: 1'b0, wr: 1'b1, dest: 3'd5, data: 32'h00000000, e_wen: 1'b1,
              e_mis: 1'b0};

    drive(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
    bus_if.dmem_ack   = 1'b0;
    bus_if.dmem_rdata = 32'h0;
    resetn = 1'b0;
    step();
    step();
    resetn = 1'b1;
    mid();
    chk_ctl("reset", 5'b00000);
    chk("reset.daddr", 32'(bus_if.dmem_addr), 32'h0);
    chk("reset.dwdata", bus_if.dmem_wdata, 32'h0);
    chk_rf("reset", 3'd0, 32'h0);

    // Back-to-back table: one bundle per cycle, results one cycle later.
    for (int i = 0; i <= 8; i++) begin
      step();
      if (i < 8) drive(1'b1, vt[i].mem, vt[i].st, vt[i].wr, vt[i].dest, vt[i].data, 32'h0);
      else       drive(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
      mid();
      if (i > 0) begin
        chk_ctl($sformatf("vec%0d", i - 1), {3'b000, vt[i-1].e_wen, vt[i-1].e_mis});
        if (vt[i-1].e_wen) chk_rf($sformatf("vec%0d", i - 1), vt[i-1].dest, vt[i-1].data);
      end
    end

    // Load with ack in the third MEM cycle.
    step();
    drive(1'b1, 1'b1, 1'b0, 1'b1, 3'd5, 32'h00000040, 32'h11111111);
    step();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
    for (int k = 0; k < 3; k++) begin
      if (k == 2) begin
        bus_if.dmem_ack   = 1'b1;
        bus_if.dmem_rdata = 32'hCAFEF00D;
      end
      mid();
      chk_ctl($sformatf("load.mem%0d", k), 5'b11000);
      chk($sformatf("load.addr%0d", k), 32'(bus_if.dmem_addr), 32'h40);
      step();
    end
    bus_if.dmem_ack = 1'b0;
    mid();
    chk_ctl("load.wb", 5'b10010);
    chk_rf("load.wb", 3'd5, 32'hCAFEF00D);
    step();
    mid();
    chk_ctl("load.done", 5'b00000);

    // Store acked immediately, ALU op accepted the cycle after ack.
    step();
    drive(1'b1, 1'b1, 1'b1, 1'b1, 3'd4, 32'h00000100, 32'hA5A5A5A5);
    step();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
    bus_if.dmem_ack = 1'b1;
    mid();
    chk_ctl("store.mem", 5'b11100);
    chk("store.addr", 32'(bus_if.dmem_addr), 32'h100);
    chk("store.wdata", bus_if.dmem_wdata, 32'hA5A5A5A5);
    step();
    bus_if.dmem_ack = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 1'b1, 3'd6, 32'h00000055, 32'h0);
    mid();
    chk_ctl("store.after", 5'b00000);
    step();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
    mid();
    chk_ctl("store.alu", 5'b00010);
    chk_rf("store.alu", 3'd6, 32'h55);

    // Reset in MEM abandons the access; a later ack is ignored.
    step();
    drive(1'b1, 1'b1, 1'b0, 1'b1, 3'd1, 32'h00000080, 32'h0);
    step();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
    mid();
    chk_ctl("rst.mem", 5'b11000);
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    mid();
    chk_ctl("rst.after", 5'b00000);
    step();
    bus_if.dmem_ack   = 1'b1;
    bus_if.dmem_rdata = 32'h00000123;
    mid();
    chk_ctl("rst.ack", 5'b00000);
    step();
    bus_if.dmem_ack = 1'b0;
    mid();
    chk_ctl("rst.noack", 5'b00000);

    // Spurious ack while idle, then a bundle held across a load stall.
    step();
    bus_if.dmem_ack = 1'b1;
    mid();
    step();
    bus_if.dmem_ack = 1'b0;
    mid();
    chk_ctl("spur.idle", 5'b00000);
    step();
    drive(1'b1, 1'b1, 1'b0, 1'b1, 3'd6, 32'h000000C0, 32'h0);
    step();
    drive(1'b1, 1'b0, 1'b0, 1'b1, 3'd2, 32'h00000077, 32'h0);
    mid();
    chk_ctl("held.mem0", 5'b11000);
    step();
    bus_if.dmem_ack   = 1'b1;
    bus_if.dmem_rdata = 32'h0BADCAFE;
    mid();
    chk_ctl("held.mem1", 5'b11000);
    step();
    bus_if.dmem_ack = 1'b0;
    mid();
    chk_ctl("held.wb", 5'b10010);
    chk_rf("held.wb", 3'd6, 32'h0BADCAFE);
    step();
    mid();
    chk_ctl("held.free", 5'b00000);
    step();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
    mid();
    chk_ctl("held.alu", 5'b00010);
    chk_rf("held.alu", 3'd2, 32'h77);
    step();
    mid();
    chk_ctl("held.once", 5'b00000);

    // Randomized instruction stream against an instruction-level model.
    for (int i = 0; i < 16; i++) mem_model[i] = $urandom;
    for (int r = 0; r < 8; r++) begin
      model_rf[r] = 32'h0;
      obs_rf[r]   = 32'h0;
    end
    rand_phase = 1'b1;
    for (int it = 0; it < 200; it++) begin
      int unsigned kind;
      int unsigned idx;
      int unsigned dly;
      logic [15:0] addr;
      logic [31:0] data;
      logic [31:0] sdata;
      logic [31:0] rdata;
      logic        st;
      logic        wr;
      logic [2:0]  dest;
      string       tag;
      kind  = $urandom_range(0, 3);
      idx   = $urandom_range(0, 15);
      dly   = $urandom_range(0, 3);
      st    = 1'($urandom);
      wr    = 1'($urandom);
      dest  = 3'($urandom);
      sdata = $urandom;
      addr  = 16'(idx * 4);
      if (kind == 3) addr = addr + 16'($urandom_range(1, 3));
      data  = (kind == 0) ? $urandom : {16'($urandom), addr};
      tag   = $sformatf("rnd%0d", it);

      step();
      if ($urandom_range(0, 3) == 0) begin
        drive(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
        bus_if.dmem_ack = 1'($urandom);
        mid();
        chk_ctl({tag, ".gap"}, 5'b00000);
        step();
        bus_if.dmem_ack = 1'b0;
      end
      drive(1'b1, kind != 0, st, wr, dest, data, sdata);
      step();
      if (kind == 0) begin
        drive(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
        mid();
        chk_ctl({tag, ".alu"}, {3'b000, wr, 1'b0});
        if (wr) begin
          chk_rf({tag, ".alu"}, dest, data);
          model_rf[dest] = data;
        end
      end else if (kind == 3) begin
        drive(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
        mid();
        chk_ctl({tag, ".mis"}, 5'b00001);
      end else begin
        rdata = mem_model[idx];
        for (int unsigned k = 0; k <= dly; k++) begin
          drive_junk();
          if (k == dly) begin
            bus_if.dmem_ack   = 1'b1;
            bus_if.dmem_rdata = st ? $urandom : rdata;
          end
          mid();
          chk_ctl({tag, ".mem"}, {3'b110 | {2'b00, st}, 2'b00});
          chk({tag, ".addr"}, 32'(bus_if.dmem_addr), 32'(addr));
          if (st) chk({tag, ".sdata"}, bus_if.dmem_wdata, sdata);
          step();
        end
        bus_if.dmem_ack = 1'b0;
        if (st) begin
          drive(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
          mid();
          chk_ctl({tag, ".stdone"}, 5'b00000);
          mem_model[idx] = sdata;
        end else begin
          drive_junk();
          mid();
          chk_ctl({tag, ".wb"}, {3'b100, wr, 1'b0});
          if (wr) begin
            chk_rf({tag, ".wb"}, dest, rdata);
            model_rf[dest] = rdata;
          end
          step();
          drive(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
          mid();
          chk_ctl({tag, ".lddone"}, 5'b00000);
        end
      end
    end
    step();
    rand_phase = 1'b0;
    for (int r = 0; r < 8; r++) chk($sformatf("regfile.r%0d", r), obs_rf[r], model_rf[r]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
